hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised successor to the EX-stage forward control. Tracks in-flight destination
//  registers through NUM_FWD_STAGES pipeline stages in an internal shift register.
//  Generates per-read-port forward-mux selects, plus a load-use stall with bubble insertion.
//  Sits beside the ID stage; consumes decoded ID fields and drives the EX operand muxes and ID/IF stall.
// PARAMETERS
//  REG_ADDR_W      5  register address width
//  NUM_READ        2  number of source-operand read ports
//  NUM_FWD_STAGES  2  forwarding stages tracked; stage 1 = EX (youngest), stage N = oldest
//  LOAD_LAT        1  a load's data is forwardable only from stages k > LOAD_LAT
// PORTS
//  clk         in   1                    clock
//  reset       in   1                    synchronous, active-high reset
//  hold        in   1                    global pipeline freeze (e.g. memory wait)
//  flush       in   1                    squash the instruction currently in ID
//  id_valid    in   1                    ID holds a real instruction
//  id_rd       in   REG_ADDR_W           ID destination register
//  id_wb_en    in   1                    ID instruction writes id_rd
//  id_is_load  in   1                    ID instruction is a load
//  id_rs       in   NUM_READ*REG_ADDR_W  flattened source registers; port p = bits [p*W +: W]
//  id_rs_used  in   NUM_READ             port p actually reads its register
//  fwd_sel     out  NUM_READ*SEL_W       per-port select; SEL_W = $clog2(NUM_FWD_STAGES+1)
//  stall       out  1                    hold IF/ID this cycle
// BEHAVIOUR
//  - Stage entry = {valid, rd, wb_en, is_load}. An entry is "live" iff valid && wb_en && rd != 0.
//  - fwd_sel encoding: 0 = register file (no forward); k = forward from stage k.
//  - Per port p with id_rs_used[p] && rs != 0: find the smallest k whose live entry matches rs.
//    The youngest match wins and older matches are ignored.
//    No match -> sel 0. Match is a load with k <= LOAD_LAT -> port requests stall and sel = 0.
//  - stall = OR of port requests, gated by id_valid, forced 0 when flush = 1.
//  - Outputs are combinational from stage registers + ID inputs: zero-cycle latency.
//  - Update on posedge clk, priority order:
//    - reset: all stage valid <= 0.
//    - else hold: all stages keep their value.
//    - else: stage[k] <= stage[k-1] for k > 1.
//      stage[1] <= bubble (valid = 0) if stall || flush || !id_valid; otherwise the ID entry.
//  - Stalled instruction re-evaluates each cycle. The load advances one stage per unheld cycle.
//    Stall clears once the load reaches stage LOAD_LAT+1; sel then = LOAD_LAT+1.
//  - hold && stall together: outputs remain valid, state frozen, stall persists.
//  - Reset mid-operation: next cycle all sel = 0, stall = 0; the ID inputs alone never raise stall.
//  - Elaboration error if NUM_FWD_STAGES < 1, LOAD_LAT >= NUM_FWD_STAGES, or NUM_READ < 1.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - Adds outputs stall_cycles[31:0] and bubble_count[31:0].
//    - Both are saturating counters, cleared by reset, frozen during hold.
//    - stall_cycles increments on every unheld cycle with stall = 1.
//    - bubble_count increments on every unheld cycle that inserts a bubble due to stall or flush.
//  HAZARD_PERF_CNT_EN undefined: those ports and counters do not exist; behaviour otherwise identical.
// STRUCTURE
//  - Package hazard_pkg:
//    - typedef hz_entry_t {valid, rd, wb_en, is_load}
//    - localparam SEL_RF = 0
//    - function sel_w(n) returning $clog2(n+1)
//  - Sub-module hazard_port_match, one instance per read port (generate loop).
//    - Inputs: rs, used, the stage array.
//    - Outputs: sel, stall_req.
//    - Youngest-first priority encoder.
//  - Top: stage shift register, bubble mux, stall OR-reduction, optional perf counters.
// TESTING  (defaults unless noted)
//  1. ADD r3 in ID, next cycle ID reads r3 on port0 -> fwd_sel[0] = 1, stall = 0.
//     One cycle later (stage 2) -> fwd_sel[0] = 2. Two cycles later -> 0.
//  2. r5 written in stage 1 and stage 2, ID reads r5 -> sel = 1 (youngest wins).
//     rd = 0 with wb_en = 1 in stage 1 and ID reads r0 -> sel = 0, no stall.
//  3. LW r4 in stage 1, ID reads r4 -> stall = 1 for exactly one cycle, bubble enters stage 1.
//     Next cycle sel = 2, stall = 0.
//     With LOAD_LAT = 2, NUM_FWD_STAGES = 3 -> stall for 2 cycles, then sel = 3.
//  4. LW r4 in stage 1 with hold = 1 for 3 cycles -> stall stays 1, stage contents unchanged.
//     After hold drops -> stall clears one cycle later.
//  5. flush = 1 while a load-use hazard exists -> stall = 0, bubble inserted, no stage entry for the flushed op.
//     Reset asserted mid-stall -> next cycle stall = 0, all sel = 0.
//  6. NUM_READ = 3: ports read r7, r7, r9 with r7 live in stage 2 and r9 an unready load in stage 1
//     -> sel = {0, 2, 2}, stall = 1.
//     With HAZARD_PERF_CNT_EN defined -> stall_cycles and bubble_count each +1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding unit: the in-flight stage
// entry, the register-file select code and the select-width function.
package hazard_pkg;

  // Widest register address a stage entry can carry; narrower files zero-extend.
  localparam int HZ_RD_W_MAX = 8;

  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                   valid;
    logic [HZ_RD_W_MAX-1:0] rd;
    logic                   wb_en;
    logic                   is_load;
  } hz_entry_t;

  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic is_live(input hz_entry_t e);
    return e.valid && e.wb_en && (e.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_port_match.sv
// One read port's forwarding decision: youngest-first search of the tracked
// stages, producing a forward select or a load-use stall request.
module hazard_port_match
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W     = 5,
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int LOAD_LAT       = 1,
  localparam int SEL_W          = sel_w(NUM_FWD_STAGES)
) (
  input  logic [REG_ADDR_W-1:0]            rs,
  input  logic                             used,
  input  hz_entry_t [NUM_FWD_STAGES-1:0]   stages,
  output logic [SEL_W-1:0]                 sel,
  output logic                             stall_req
);

  logic hit;
  logic hit_load;
  int   hit_k;

  // NOTE: every variable gets a default before any conditional write so no latch is inferred.
  always_comb begin
    sel       = SEL_W'(SEL_RF);
    stall_req = 1'b0;
    hit       = 1'b0;
    hit_load  = 1'b0;
    hit_k     = 0;
    if (used && (rs != '0)) begin
      // Scan oldest to youngest so the youngest match is the last one written.
      for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
        if (is_live(stages[k-1]) && (stages[k-1].rd == HZ_RD_W_MAX'(rs))) begin
          hit      = 1'b1;
          hit_load = stages[k-1].is_load;
          hit_k    = k;
        end
      end
    end
    if (hit) begin
      if (hit_load && (hit_k <= LOAD_LAT)) stall_req = 1'b1;
      else                                 sel       = SEL_W'(hit_k);
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard unit: tracks in-flight destinations, drives EX forward selects
// and the load-use stall. Define HAZARD_PERF_CNT_EN to add stall/bubble counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W     = 5,
  parameter  int NUM_READ       = 2,
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int LOAD_LAT       = 1,
  localparam int SEL_W          = sel_w(NUM_FWD_STAGES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic                           flush,
  input  logic                           id_valid,
  input  logic [REG_ADDR_W-1:0]          id_rd,
  input  logic                           id_wb_en,
  input  logic                           id_is_load,
  input  logic [NUM_READ*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_READ-1:0]            id_rs_used,
  output logic [NUM_READ*SEL_W-1:0]      fwd_sel,
  output logic                           stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                    stall_cycles,
  output logic [31:0]                    bubble_count
`endif
);

  if (NUM_FWD_STAGES < 1) begin : g_err_stages
    $error("hazard_forward_unit: NUM_FWD_STAGES must be >= 1");
  end
  if (LOAD_LAT >= NUM_FWD_STAGES) begin : g_err_lat
    $error("hazard_forward_unit: LOAD_LAT must be < NUM_FWD_STAGES");
  end
  if (NUM_READ < 1) begin : g_err_read
    $error("hazard_forward_unit: NUM_READ must be >= 1");
  end
  if ((REG_ADDR_W < 1) || (REG_ADDR_W > HZ_RD_W_MAX)) begin : g_err_addr
    $error("hazard_forward_unit: REG_ADDR_W out of supported range");
  end

  hz_entry_t [NUM_FWD_STAGES-1:0] stages;
  hz_entry_t                      id_entry;
  logic [NUM_READ-1:0]            stall_req;
  logic                           insert_bubble;

  assign id_entry = '{valid:   1'b1,
                      rd:      HZ_RD_W_MAX'(id_rd),
                      wb_en:   id_wb_en,
                      is_load: id_is_load};

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    hazard_port_match #(
      .REG_ADDR_W     (REG_ADDR_W),
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .LOAD_LAT       (LOAD_LAT)
    ) u_match (
      .rs        (id_rs[p*REG_ADDR_W +: REG_ADDR_W]),
      .used      (id_rs_used[p]),
      .stages    (stages),
      .sel       (fwd_sel[p*SEL_W +: SEL_W]),
      .stall_req (stall_req[p])
    );
  end

  assign stall         = id_valid && !flush && (|stall_req);
  assign insert_bubble = stall || flush || !id_valid;

  // NOTE: only the valid bits are reset; the payload is don't-care while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_FWD_STAGES; k++) stages[k].valid <= 1'b0;
    end else if (!hold) begin
      for (int k = NUM_FWD_STAGES - 1; k >= 1; k--) stages[k] <= stages[k-1];
      stages[0] <= insert_bubble ? '0 : id_entry;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      bubble_count <= '0;
    end else if (!hold) begin
      if (stall && (stall_cycles != '1))               stall_cycles <= stall_cycles + 32'd1;
      if ((stall || flush) && (bubble_count != '1))    bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: three configurations (default,
// LOAD_LAT=2/3 stages, 3 read ports) driven with hand-computed directed vectors.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        hold = 1'b0, flush = 1'b0;
  logic        id_valid = 1'b0, id_wb_en = 1'b0, id_is_load = 1'b0;
  logic [4:0]  id_rd = '0;
  logic [14:0] id_rs = '0;
  logic [2:0]  id_rs_used = '0;

  logic [3:0]  sel0, sel1;
  logic [5:0]  sel2;
  logic        st0, st1, st2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc0, bc0, sc1, bc1, sc2, bc2;
`endif

  hazard_forward_unit u_def (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .id_rs(id_rs[9:0]), .id_rs_used(id_rs_used[1:0]), .fwd_sel(sel0), .stall(st0)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc0), .bubble_count(bc0)
`endif
  );

  hazard_forward_unit #(.NUM_FWD_STAGES(3), .LOAD_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .id_rs(id_rs[9:0]), .id_rs_used(id_rs_used[1:0]), .fwd_sel(sel1), .stall(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc1), .bubble_count(bc1)
`endif
  );

  hazard_forward_unit #(.NUM_READ(3)) u_r3 (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .fwd_sel(sel2), .stall(st2)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc2), .bubble_count(bc2)
`endif
  );

  typedef struct {
    int         dut;
    string      name;
    logic [5:0] sel;
    logic       stall;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so one expectation is due per driven cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      case (mon_e.dut)
        0: begin
          check({mon_e.name, "_sel"},   32'(sel0), 32'(mon_e.sel));
          check({mon_e.name, "_stall"}, 32'(st0),  32'(mon_e.stall));
        end
        1: begin
          check({mon_e.name, "_sel"},   32'(sel1), 32'(mon_e.sel));
          check({mon_e.name, "_stall"}, 32'(st1),  32'(mon_e.stall));
        end
        default: begin
          check({mon_e.name, "_sel"},   32'(sel2), 32'(mon_e.sel));
          check({mon_e.name, "_stall"}, 32'(st2),  32'(mon_e.stall));
        end
      endcase
    end
  end

  // One cycle of stimulus; d < 0 drives without scoring.
  task automatic cyc(input int d, input string nm, input int rst, input int v, input int rd,
                     input int wb, input int ld, input int rs0, input int rs1, input int rs2,
                     input int used, input int hd, input int fl, input int esel, input int est);
    @(posedge clk);
    #1;
    reset      = (rst != 0);
    id_valid   = (v != 0);
    id_rd      = 5'(rd);
    id_wb_en   = (wb != 0);
    id_is_load = (ld != 0);
    id_rs      = {5'(rs2), 5'(rs1), 5'(rs0)};
    id_rs_used = 3'(used);
    hold       = (hd != 0);
    flush      = (fl != 0);
    if (d >= 0) q.push_back('{dut: d, name: nm, sel: 6'(esel), stall: (est != 0)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //  d  name               rst v  rd wb ld rs0 rs1 rs2 used  hd fl  esel       est
    cyc(-1, "rst",            1,  0, 0, 0, 0, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(-1, "rst",            1,  0, 0, 0, 0, 0,  0,  0,  0,    0, 0,  0,         0);
    // Basic forwarding and ageing
    cyc(0, "t1_empty",        0,  1, 3, 1, 0, 3,  3,  0,  'b011, 0, 0, 0,         0);
    cyc(0, "t1_sel1",         0,  1, 6, 1, 0, 3,  0,  0,  'b001, 0, 0, 'b000001,  0);
    cyc(0, "t1_sel2",         0,  1, 0, 0, 0, 3,  0,  0,  'b001, 0, 0, 'b000010,  0);
    cyc(0, "t1_aged",         0,  0, 0, 0, 0, 3,  6,  0,  'b011, 0, 0, 'b001000,  0);
    // Youngest match wins; r0 never forwards
    cyc(0, "t2_fill",         0,  1, 5, 1, 0, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(0, "t2_fill2",        0,  1, 5, 1, 0, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(0, "t2_youngest",     0,  1, 0, 1, 0, 0,  5,  0,  'b010, 0, 0, 'b000100,  0);
    cyc(0, "t2_r0",           0,  1, 4, 1, 1, 0,  0,  0,  'b011, 0, 0, 0,         0);
    // Load-use: one stall cycle, then forward from stage 2
    cyc(0, "t3_stall",        0,  1, 7, 1, 0, 4,  0,  0,  'b001, 0, 0, 0,         1);
    cyc(0, "t3_sel2",         0,  1, 7, 1, 0, 4,  0,  0,  'b001, 0, 0, 'b000010,  0);
    // Hold freezes a stalled load
    cyc(0, "t4_load",         0,  1, 4, 1, 1, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(0, "t4_hold1",        0,  1, 8, 1, 0, 0,  4,  0,  'b010, 1, 0, 0,         1);
    cyc(0, "t4_hold2",        0,  1, 8, 1, 0, 0,  4,  0,  'b010, 1, 0, 0,         1);
    cyc(0, "t4_hold3",        0,  1, 8, 1, 0, 0,  4,  0,  'b010, 1, 0, 0,         1);
    cyc(0, "t4_release",      0,  1, 8, 1, 0, 0,  4,  0,  'b010, 0, 0, 0,         1);
    cyc(0, "t4_clear",        0,  1, 8, 1, 0, 0,  4,  0,  'b010, 0, 0, 'b001000,  0);
    // Flush suppresses stall and drops the op
    cyc(0, "t5_load",         0,  1, 9, 1, 1, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(0, "t5_flush",        0,  1, 10, 1, 0, 9, 0,  0,  'b001, 0, 1, 0,         0);
    cyc(0, "t5_noentry",      0,  1, 0, 0, 0, 10, 9,  0,  'b011, 0, 0, 'b001000,  0);
    // Reset in the middle of a stall
    cyc(0, "t5_load2",        0,  1, 11, 1, 1, 0, 0,  0,  0,    0, 0,  0,         0);
    cyc(0, "t5_holdstall",    0,  1, 12, 1, 0, 11, 0, 0,  'b001, 1, 0, 0,         1);
    cyc(0, "t5_rst_edge",     1,  1, 12, 1, 0, 11, 0, 0,  'b001, 0, 0, 0,         1);
    cyc(0, "t5_after_rst",    0,  1, 12, 1, 0, 11, 0, 0,  'b001, 0, 0, 0,         0);
    cyc(0, "t5_fwd_after",    0,  0, 0, 0, 0, 12, 0,  0,  'b001, 0, 0, 'b000001,  0);

    // LOAD_LAT = 2, three stages: two stall cycles, then select 3
    cyc(-1, "rst",            1,  0, 0, 0, 0, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(1, "ll2_load",        0,  1, 4, 1, 1, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(1, "ll2_stall1",      0,  1, 5, 1, 0, 4,  0,  0,  'b001, 0, 0, 0,         1);
    cyc(1, "ll2_stall2",      0,  1, 5, 1, 0, 4,  0,  0,  'b001, 0, 0, 0,         1);
    cyc(1, "ll2_sel3",        0,  1, 5, 1, 0, 4,  0,  0,  'b001, 0, 0, 'b000011,  0);

    // Three read ports: r7,r7 forward from stage 2, r9 load in stage 1 stalls
    cyc(-1, "rst",            1,  0, 0, 0, 0, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(2, "r3_add",          0,  1, 7, 1, 0, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(2, "r3_load",         0,  1, 9, 1, 1, 0,  0,  0,  0,    0, 0,  0,         0);
    cyc(2, "r3_mixed",        0,  1, 0, 0, 0, 7,  7,  9,  'b111, 0, 0, 'b001010,  1);
`ifdef HAZARD_PERF_CNT_EN
    @(posedge clk);
    #1;
    id_valid   = 1'b0;
    id_rs_used = '0;
    check("perf_stall_cycles", sc2, 32'd1);
    check("perf_bubble_count", bc2, 32'd1);
`endif

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
